fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction fetch stage directly downstream of the 8-bit program counter.
- Reads the PC value, fetches 1- or 2-byte instructions from 8-bit program memory over a req/ack handshake, and presents them to decode via a valid/ready handshake.
- Tells the PC when to step (increment) or load (branch redirect).

Parameters:
- HALT_OP, 8'hFF, opcode that stops fetching after it is issued.
- ARG_BIT, 7, opcode bit index; when this bit is 1 the instruction carries one operand byte.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- run  in  1  fetch enable; sampled in IDLE and at issue handshake
- pc_in  in  8  current PC value
- pc_step  out  1  PC increment strobe; one cycle wide
- pc_load  out  1  PC load strobe; one cycle wide
- pc_target  out  8  PC load value; meaningful only when pc_load=1
- mem_req  out  1  program-memory read request
- mem_addr  out  8  read address; equals pc_in while mem_req=1, else 8'h00
- mem_ack  in  1  read data valid this cycle
- mem_rdata  in  8  read data
- instr_valid  out  1  instruction available to decode
- instr_ready  in  1  decode accepts
- instr_op  out  8  opcode
- instr_arg  out  8  operand byte; 8'h00 when the opcode has no operand
- instr_pc  out  8  address of the opcode byte
- redirect  in  1  branch/jump request
- redirect_addr  in  8  branch target
- halted  out  1  high in HALT

Behaviour:
- Reset (rst=0, async): state=IDLE.
  - All outputs 0: pc_step, pc_load, pc_target, mem_req, mem_addr, instr_valid, instr_op, instr_arg, instr_pc, halted.
  - Reset overrides every state, including a request in flight; a later mem_ack for that request is ignored.
- States: IDLE, REQ_OP, STEP_OP, REQ_ARG, STEP_ARG, ISSUE, LOAD, HALT.
- IDLE: run=1 -> REQ_OP.
- REQ_OP:
  - mem_req=1, mem_addr=pc_in; hold until mem_ack.
  - On ack: instr_op<=mem_rdata, instr_pc<=pc_in, instr_arg<=8'h00 -> STEP_OP.
- STEP_OP: pc_step=1 for exactly this cycle, so the PC holds the new value next cycle.
  - If instr_op[ARG_BIT]=1 -> REQ_ARG, else -> ISSUE.
- REQ_ARG: like REQ_OP; on ack instr_arg<=mem_rdata -> STEP_ARG.
- STEP_ARG: pc_step=1 for one cycle -> ISSUE.
- ISSUE: instr_valid=1, with op/arg/pc held stable until instr_ready=1.
  - On handshake: if instr_op==HALT_OP -> HALT.
  - Else run=1 -> REQ_OP.
  - Else -> IDLE.
- HALT: halted=1, no requests, redirect ignored; exits only via reset.
- Redirect (any state except HALT and LOAD): next state LOAD.
  - In LOAD: pc_load=1, pc_target=redirect_addr as registered on entry. Lasts one cycle, then -> REQ_OP if run=1, else IDLE.
  - The in-flight fetch is discarded: instr_valid drops, and mem_ack coinciding with redirect is ignored.
  - redirect in the same cycle as an ISSUE handshake: the instruction counts as consumed; redirect still wins. A HALT_OP consumed this way does not halt.
- Timing:
  - pc_step and pc_load are never both 1.
  - mem_req is never high in STEP/LOAD cycles, so mem_addr never sees a PC mid-update.
  - Minimum fetch-to-issue with zero-wait memory: 1-byte instruction, 3 cycles (REQ_OP, STEP_OP, ISSUE valid); 2-byte instruction, 5 cycles.
- mem_ack outside REQ_OP/REQ_ARG is ignored.
- PC arithmetic belongs to the counter; 8'hFF+1 wraps to 8'h00, and fetch follows pc_in without special-casing.

Test Plan:
- Reset, run=1, pc_in=8'h10, zero-wait memory returns 8'h05 -> mem_addr=8'h10, one pc_step pulse, instr_valid=1 with op=8'h05, arg=8'h00, instr_pc=8'h10.
- Opcode 8'h83 at 8'h20, operand 8'h44 at 8'h21, mem_ack delayed 3 cycles each -> two pc_step pulses; issue op=8'h83, arg=8'h44, instr_pc=8'h20; mem_req stays high through the waits.
- instr_ready held 0 for 5 cycles in ISSUE -> instr_valid and outputs stable; no mem_req, no pc_step until ready.
- redirect=1 with redirect_addr=8'h7A in the same cycle as mem_ack in REQ_ARG -> data discarded, one-cycle pc_load with pc_target=8'h7A, then REQ_OP; no instr_valid for the aborted instruction.
- Fetch 8'hFF, handshake -> halted=1, mem_req=0 indefinitely, redirect ignored; rst low -> halted=0, state IDLE.
- rst asserted while mem_req=1 in REQ_OP -> all outputs 0 immediately (async); mem_ack after rst release ignored until a new REQ_OP.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: pulls 1/2-byte instructions from program memory
// and hands them to decode, steering the PC with step/load strobes.
module fetch_unit #(
  parameter logic [7:0] HALT_OP = 8'hFF,
  parameter int         ARG_BIT = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [7:0] pc_in,
  output logic       pc_step,
  output logic       pc_load,
  output logic [7:0] pc_target,
  output logic       mem_req,
  output logic [7:0] mem_addr,
  input  logic       mem_ack,
  input  logic [7:0] mem_rdata,
  output logic       instr_valid,
  input  logic       instr_ready,
  output logic [7:0] instr_op,
  output logic [7:0] instr_arg,
  output logic [7:0] instr_pc,
  input  logic       redirect,
  input  logic [7:0] redirect_addr,
  output logic       halted
);

  typedef enum logic [2:0] {
    IDLE,
    REQ_OP,
    STEP_OP,
    REQ_ARG,
    STEP_ARG,
    ISSUE,
    LOAD,
    HALT
  } state_t;

  state_t state;
  state_t nxt;
  logic   take_ack;

  // Address is gated so it only tracks the PC while a request is live.
  assign mem_addr = mem_req ? pc_in : 8'h00;
  assign take_ack = mem_ack && !redirect;

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:     if (run) nxt = REQ_OP;
      REQ_OP:   if (mem_ack) nxt = STEP_OP;
      STEP_OP:  nxt = instr_op[ARG_BIT] ? REQ_ARG : ISSUE;
      REQ_ARG:  if (mem_ack) nxt = STEP_ARG;
      STEP_ARG: nxt = ISSUE;
      ISSUE: begin
        if (instr_ready) begin
          if (instr_op == HALT_OP) nxt = HALT;
          else if (run)            nxt = REQ_OP;
          else                     nxt = IDLE;
        end
      end
      LOAD:     nxt = run ? REQ_OP : IDLE;
      HALT:     nxt = HALT;
    endcase
    if (redirect && state != HALT && state != LOAD)
      nxt = LOAD;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      mem_req     <= 1'b0;
      pc_step     <= 1'b0;
      pc_load     <= 1'b0;
      pc_target   <= 8'h00;
      instr_valid <= 1'b0;
      instr_op    <= 8'h00;
      instr_arg   <= 8'h00;
      instr_pc    <= 8'h00;
      halted      <= 1'b0;
    end else begin
      state       <= nxt;
      mem_req     <= (nxt == REQ_OP) || (nxt == REQ_ARG);
      pc_step     <= (nxt == STEP_OP) || (nxt == STEP_ARG);
      pc_load     <= (nxt == LOAD);
      instr_valid <= (nxt == ISSUE);
      halted      <= (nxt == HALT);
      if (nxt == LOAD)
        pc_target <= redirect_addr;
      if (take_ack && state == REQ_OP) begin
        instr_op  <= mem_rdata;
        instr_pc  <= pc_in;
        instr_arg <= 8'h00;
      end
      if (take_ack && state == REQ_ARG)
        instr_arg <= mem_rdata;
    end
  end

endmodule
